adc_pair_reader: RTL and testbench
==================================

# adc_pair_reader

Serial master for a 2-channel 12-bit SPI ADC (MCP3202-style) that produces the two player voltage words consumed by the single- and multi-player screen logic. The block runs continuous conversions, channel 0 then channel 1, with a fixed idle gap between them. It drives SCLK, CS_N and the command line, and deserialises the returned code into `p1data` / `p2data`. After each completed pair it raises a one-cycle `valid` strobe.

## Interface
- `CLK_DIV`, default 24: `clk` cycles per SCLK half-period; legal range ≥ 1.
- `GAP_CYCLES`, default 1000: `clk` cycles that `cs_n` stays high between conversions; legal range ≥ 1.

Ports:
- `clk` input, 1 bit: system clock.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `enable` input, 1 bit: run conversions while high.
- `adc_miso` input, 1 bit: ADC DOUT.
- `adc_sclk` output, 1 bit: SPI clock, idles low.
- `adc_cs_n` output, 1 bit: ADC chip select, active low.
- `adc_mosi` output, 1 bit: ADC DIN, carries command bits.
- `p1data` output, 12 bits: latest channel-0 code.
- `p2data` output, 12 bits: latest channel-1 code.
- `valid` output, 1 bit: one-cycle pulse when a new pair has been published.

## Operation
- **States:**
  - IDLE: `cs_n` high.
  - CONV: `cs_n` low, SCLK running.
  - DONE: latch the result.
  - GAP: `cs_n` high.
- **Channel tracking:** a 1-bit `ch` register selects the current channel and resets to 0.
- **IDLE → CONV:** taken when `enable` is high. `enable` is sampled only in IDLE, so a pair that has started always completes (ch0 and ch1).
- **CONV:**
  - A half-period counter `h` runs 0..33; each value of `h` lasts `CLK_DIV` clk cycles.
  - `adc_sclk` is 0 when `h` is even and 1 when `h` is odd, giving 17 rising edges.
  - `h` = 0 is the CS-to-SCLK setup interval.
- **Command (`adc_mosi`):** driven at the start of `h` = 0, 2, 4, 6 with the bits start=1, SGL=1, ODD=`ch`, MSBF=1, in that order. From `h` = 8 onward `adc_mosi` is 0.
- **Data capture (`adc_miso`):**
  - Sampled in the first clk cycle of each odd `h`.
  - Rising edges 1–5 (`h` = 1..9) are ignored; edge 5 is the null bit.
  - Edges 6–17 (`h` = 11..33) shift D11..D0 into a 12-bit shift register, MSB first.
- **CONV → DONE:** after the last cycle of `h` = 33, `adc_sclk` returns to 0 and `adc_cs_n` goes to 1.
- **DONE (one cycle):**
  - `ch` = 0: hold the shift register contents in a staging register.
  - `ch` = 1: write `p1data` ← staging and `p2data` ← shift register, and assert `valid` in the same cycle. Both outputs therefore always update together.
  - Toggle `ch`.
- **DONE → GAP → next state:**
  - GAP lasts `GAP_CYCLES` cycles.
  - If `ch` = 1, go straight to CONV.
  - If `ch` = 0, go to IDLE (which re-checks `enable`).
- **Data stability:** `p1data` and `p2data` hold their values between `valid` pulses.
- **Reset values (asynchronous, any state):**
  - `adc_sclk` = 0, `adc_cs_n` = 1, `adc_mosi` = 0.
  - `p1data` = 0, `p2data` = 0, `valid` = 0.
  - State = IDLE, `ch` = 0; the staging register, shift register and counters are cleared.
- **Reset during CONV:** the partial conversion is discarded and no `valid` is produced.

## Timing
- **Conversion:** 34·`CLK_DIV` cycles with `cs_n` low, followed by 1 DONE cycle and `GAP_CYCLES` cycles with `cs_n` high.
- **Pair period:** 2·(34·`CLK_DIV` + 1 + `GAP_CYCLES`) cycles, plus 1 IDLE cycle.
- **First pair latency:** the first `valid` occurs 2·34·`CLK_DIV` + `GAP_CYCLES` + 3 cycles after `enable` is first seen high in IDLE, counting the first IDLE cycle.
- **SCLK shape:** period 2·`CLK_DIV`, 50% duty, glitch-free. All outputs are registered.
- **`valid` width:** exactly one cycle, never back-to-back.

## Configuration
- **`ADC_AVG_EN` defined:**
  - Each channel keeps a 4-deep history of 12-bit codes, cleared to 0 on reset, plus a 14-bit running sum.
  - In the DONE cycle that publishes a pair, the new code enters each history, the sum updates as sum + new − oldest, and the published value is sum[13:2].
  - `valid` timing is unchanged.
  - The first three pairs ramp up from 0 because the history starts at zero.
- **`ADC_AVG_EN` undefined:** raw codes are published, and no history registers or adders exist.

## Test plan
Parameters for all scenarios: `CLK_DIV` = 2, `GAP_CYCLES` = 4. The bench uses an ADC behavioural model that decodes the command bits and drives `adc_miso` on SCLK falling edges.

1. **Reset state:** reset held low with `enable` = 1 → `adc_cs_n` = 1, `adc_sclk` = 0, `adc_mosi` = 0, `p1data` = `p2data` = 0x000, `valid` = 0; release reset → CS falls within 2 cycles.
2. **Basic pair:** model returns ch0 = 0xABC, ch1 = 0x123 → MOSI command bits 1,1,0,1 then 1,1,1,1; after the first pair, `p1data` = 0xABC and `p2data` = 0x123, updated in the same cycle as a single `valid` pulse.
3. **SCLK framing:** across two pairs, count signal activity → exactly 17 SCLK rising edges per `cs_n`-low window, SCLK period 4 cycles, `cs_n` low for 68 cycles and high for ≥ 5 cycles between conversions.
4. **Enable drop mid-pair:** deassert `enable` during the ch0 conversion → the ch1 conversion still runs, `valid` pulses once, then `cs_n` stays high and no further SCLK edges occur; reassert `enable` → conversions resume with ch0.
5. **Reset mid-conversion:** pulse reset during ch1 CONV with prior data 0xABC / 0x123 present → outputs go to their reset values immediately, `p1data` = `p2data` = 0, and no `valid` until a full new pair completes.
6. **Averaging (`ADC_AVG_EN`):** model holds ch0 = 0x800, ch1 = 0x400 → successive `valid` pulses show `p1data` = 0x200, 0x400, 0x600, 0x800, 0x800 and `p2data` = 0x100, 0x200, 0x300, 0x400, 0x400.

Source files
------------

// File: rtl/adc_pair_reader.sv
// adc_pair_reader: MCP3202-style SPI master converting ch0 then ch1 continuously and publishing each pair.
// Define ADC_AVG_EN to publish a 4-sample running average per channel instead of raw codes.
module adc_pair_reader #(
  parameter int CLK_DIV    = 24,
  parameter int GAP_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        adc_miso,
  output logic        adc_sclk,
  output logic        adc_cs_n,
  output logic        adc_mosi,
  output logic [11:0] p1data,
  output logic [11:0] p2data,
  output logic        valid
);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, CONV, DONE, GAP} state_t;
  state_t state;
  logic ch;
  logic [DW-1:0] d;
  logic [5:0] h, hn;
  logic [GW-1:0] g;
  logic [11:0] sr, stage;
  logic last_div, gap_end, start;
  assign hn = h + 6'd1;
  assign last_div = d == DW'(CLK_DIV - 1);
  assign gap_end = g == GW'(GAP_CYCLES - 1);
  assign start = (state == IDLE && enable) || (state == GAP && gap_end && ch);
  // Command bits start, SGL, ODD=ch, MSBF, each held over one SCLK period.
  function automatic logic cmd(input logic [5:0] x, input logic c);
    return x < 6'd8 && (x[2:1] != 2'd2 || c);
  endfunction
`ifdef ADC_AVG_EN
  logic [11:0] h1 [4];
  logic [11:0] h2 [4];
  logic [13:0] s1, s2, s1n, s2n;
  always_comb begin
    s1n = s1 + 14'(stage) - 14'(h1[3]);
    s2n = s2 + 14'(sr) - 14'(h2[3]);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      h1 <= '{default: '0};
      h2 <= '{default: '0};
      s1 <= '0;
      s2 <= '0;
    end else if (state == DONE && ch) begin
      h1 <= '{stage, h1[0], h1[1], h1[2]};
      h2 <= '{sr, h2[0], h2[1], h2[2]};
      s1 <= s1n;
      s2 <= s2n;
    end
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      ch <= 1'b0;
      d <= '0;
      h <= '0;
      g <= '0;
      sr <= '0;
      stage <= '0;
      adc_sclk <= 1'b0;
      adc_cs_n <= 1'b1;
      adc_mosi <= 1'b0;
      p1data <= '0;
      p2data <= '0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (start) begin
        state <= CONV;
        adc_cs_n <= 1'b0;
        adc_mosi <= 1'b1;
        h <= '0;
        d <= '0;
      end else
        case (state)
          CONV: begin
            if (d == '0 && h[0] && h >= 6'd11) sr <= {sr[10:0], adc_miso};
            if (!last_div) d <= d + DW'(1);
            else begin
              d <= '0;
              if (h == 6'd33) begin
                state <= DONE;
                adc_sclk <= 1'b0;
                adc_cs_n <= 1'b1;
                adc_mosi <= 1'b0;
              end else begin
                h <= hn;
                adc_sclk <= hn[0];
                adc_mosi <= cmd(hn, ch);
              end
            end
          end
          DONE: begin
            ch <= ~ch;
            state <= GAP;
            g <= '0;
            if (!ch) stage <= sr;
            else begin
              valid <= 1'b1;
`ifdef ADC_AVG_EN
              p1data <= s1n[13:2];
              p2data <= s2n[13:2];
`else
              p1data <= stage;
              p2data <= sr;
`endif
            end
          end
          GAP: if (gap_end) state <= IDLE; else g <= g + GW'(1);
          default: ;
        endcase
    end
endmodule

// File: tb/tb_adc_pair_reader.sv
// tb_adc_pair_reader: randomized bench with an ADC model and a pair-history reference for adc_pair_reader.
module tb_adc_pair_reader;
  logic clk = 0, reset = 0, enable = 0, miso = 0;
  logic sclk, cs_n, mosi, valid;
  logic [11:0] p1, p2;
  int n_chk = 0, n_fail = 0;
  logic [11:0] code0 = 0, code1 = 0;
  logic [3:0] cmd;
  logic [3:0] cmdq[$];
  int k = 0;
  int q0[$], q1[$];

  adc_pair_reader #(.CLK_DIV(2), .GAP_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .adc_miso(miso),
    .adc_sclk(sclk), .adc_cs_n(cs_n), .adc_mosi(mosi),
    .p1data(p1), .p2data(p2), .valid(valid)
  );

  always #5 clk = ~clk;

  // ADC model: latch 4 command bits on rising edges 1-4, shift code out after falling edges 5..16.
  always @(negedge cs_n) k = 0;
  always @(posedge sclk) if (!cs_n) begin
    k++;
    if (k <= 4) cmd = {cmd[2:0], mosi};
    if (k == 4) cmdq.push_back(cmd);
  end
  always @(negedge sclk) if (!cs_n) begin
    logic [11:0] cur;
    cur = cmd[1] ? code1 : code0;
    miso = (k >= 5 && k <= 16) ? cur[16-k] : 1'b0;
  end

  // Reference: what a published pair should read given the codes converted so far.
  function automatic logic [11:0] expv(input int q[$]);
    int s = 0;
`ifdef ADC_AVG_EN
    for (int i = 0; i < 4 && i < q.size(); i++) s += q[q.size()-1-i];
    return 12'(s / 4);
`else
    s = q[q.size()-1];
    return 12'(s);
`endif
  endfunction

  task automatic until_valid(input int lim, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!valid && n < lim);
    if (!valid) n = -1;
  endtask

  task automatic until_cs(input logic lvl, input int lim, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (cs_n !== lvl && n < lim);
    if (cs_n !== lvl) n = -1;
  endtask

  task automatic test_reset;
    int n;
    reset = 0; enable = 1;
    repeat (3) @(negedge clk);
    n_chk += 6;
    if (cs_n !== 1) begin n_fail++; $display("FAIL reset_cs_n got %b want 1", cs_n); end
    if (sclk !== 0) begin n_fail++; $display("FAIL reset_sclk got %b want 0", sclk); end
    if (mosi !== 0) begin n_fail++; $display("FAIL reset_mosi got %b want 0", mosi); end
    if (p1 !== 0) begin n_fail++; $display("FAIL reset_p1 got %h want 000", p1); end
    if (p2 !== 0) begin n_fail++; $display("FAIL reset_p2 got %h want 000", p2); end
    if (valid !== 0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
    reset = 1;
    until_cs(1'b0, 2, n);
    n_chk++;
    if (n < 0) begin n_fail++; $display("FAIL cs_fall got none want within 2 cycles"); end
  endtask

  task automatic test_basic_pair;
    int n;
    logic [11:0] b1, b2;
    n = 0; b1 = p1; b2 = p2;
    while (!valid && n < 400) begin b1 = p1; b2 = p2; @(negedge clk); n++; end
    q0.push_back(code0); q1.push_back(code1);
    n_chk += 7;
    if (!valid) begin n_fail++; $display("FAIL basic_valid got timeout want pulse"); end
    if (b1 !== 0 || b2 !== 0) begin n_fail++; $display("FAIL basic_pre got %h/%h want 000/000", b1, b2); end
    if (p1 !== expv(q0)) begin n_fail++; $display("FAIL basic_p1 got %h want %h", p1, expv(q0)); end
    if (p2 !== expv(q1)) begin n_fail++; $display("FAIL basic_p2 got %h want %h", p2, expv(q1)); end
    if (cmdq.size() < 2 || cmdq[0] !== 4'b1101) begin n_fail++; $display("FAIL basic_cmd0 got %b want 1101", cmdq.size() ? cmdq[0] : 4'bx); end
    if (cmdq.size() < 2 || cmdq[1] !== 4'b1111) begin n_fail++; $display("FAIL basic_cmd1 got %b want 1111", cmdq.size() > 1 ? cmdq[1] : 4'bx); end
    @(negedge clk);
    if (valid !== 0) begin n_fail++; $display("FAIL basic_width got %b want 0", valid); end
  endtask

  task automatic test_framing;
    int n, cyc, low, high, rises, last, windows;
    logic pc, ps, started;
    until_cs(1'b1, 200, n);
    pc = 1; ps = 0; started = 0; cyc = 0; low = 0; high = 0; rises = 0; last = 0; windows = 0;
    while (windows < 4 && cyc < 1000) begin
      @(negedge clk); cyc++;
      if (!cs_n) begin
        if (pc) begin
          if (started) begin
            n_chk++;
            if (high < 5) begin n_fail++; $display("FAIL frame_gap got %0d want >=5", high); end
          end
          low = 0; rises = 0;
        end
        low++;
        if (sclk && !ps) begin
          if (rises > 0) begin
            n_chk++;
            if (cyc - last != 4) begin n_fail++; $display("FAIL frame_period got %0d want 4", cyc - last); end
          end
          rises++; last = cyc;
        end
      end else begin
        if (!pc) begin
          windows++; started = 1; high = 0;
          n_chk += 2;
          if (rises != 17) begin n_fail++; $display("FAIL frame_rises got %0d want 17", rises); end
          if (low != 68) begin n_fail++; $display("FAIL frame_low got %0d want 68", low); end
        end
        high++;
        if (sclk !== 0) begin n_chk++; n_fail++; $display("FAIL frame_sclk_idle got %b want 0", sclk); end
      end
      pc = cs_n; ps = sclk;
    end
    n_chk++;
    if (windows != 4) begin n_fail++; $display("FAIL frame_windows got %0d want 4", windows); end
  endtask

  task automatic test_random;
    int n, bad;
    logic [11:0] h1, h2;
    until_valid(400, n);
    q0.push_back(code0); q1.push_back(code1);
    repeat (6) begin
      code0 = 12'($urandom); code1 = 12'($urandom);
      h1 = p1; h2 = p2; bad = 0; n = 0;
      do begin
        @(negedge clk); n++;
        if (!valid && (p1 !== h1 || p2 !== h2)) bad++;
      end while (!valid && n < 400);
      q0.push_back(code0); q1.push_back(code1);
      n_chk += 4;
      if (!valid) begin n_fail++; $display("FAIL rand_valid got timeout want pulse"); end
      if (bad != 0) begin n_fail++; $display("FAIL rand_hold got %0d changes want 0", bad); end
      if (p1 !== expv(q0)) begin n_fail++; $display("FAIL rand_p1 got %h want %h", p1, expv(q0)); end
      if (p2 !== expv(q1)) begin n_fail++; $display("FAIL rand_p2 got %h want %h", p2, expv(q1)); end
    end
  endtask

  task automatic test_enable_drop;
    int n, lows, rises, vals, sz;
    logic ps;
    until_cs(1'b0, 200, n);
    repeat (10) @(negedge clk);
    enable = 0;
    until_valid(400, n);
    q0.push_back(code0); q1.push_back(code1);
    n_chk += 3;
    if (n < 0) begin n_fail++; $display("FAIL drop_valid got timeout want pulse"); end
    if (p1 !== expv(q0)) begin n_fail++; $display("FAIL drop_p1 got %h want %h", p1, expv(q0)); end
    if (p2 !== expv(q1)) begin n_fail++; $display("FAIL drop_p2 got %h want %h", p2, expv(q1)); end
    lows = 0; rises = 0; vals = 0; ps = sclk;
    repeat (20) @(negedge clk);
    repeat (400) begin
      @(negedge clk);
      if (!cs_n) lows++;
      if (sclk && !ps) rises++;
      if (valid) vals++;
      ps = sclk;
    end
    n_chk += 3;
    if (lows != 0) begin n_fail++; $display("FAIL drop_cs got %0d low cycles want 0", lows); end
    if (rises != 0) begin n_fail++; $display("FAIL drop_sclk got %0d edges want 0", rises); end
    if (vals != 0) begin n_fail++; $display("FAIL drop_extra_valid got %0d want 0", vals); end
    sz = cmdq.size();
    enable = 1;
    until_cs(1'b0, 4, n);
    n = 0;
    while (cmdq.size() == sz && n < 100) begin @(negedge clk); n++; end
    n_chk += 2;
    if (cmdq.size() == sz) begin n_fail++; $display("FAIL resume_cmd got none want 1101"); end
    else if (cmdq[sz] !== 4'b1101) begin n_fail++; $display("FAIL resume_cmd got %b want 1101", cmdq[sz]); end
    until_valid(400, n);
    q0.push_back(code0); q1.push_back(code1);
    if (p1 !== expv(q0) || p2 !== expv(q1)) begin n_fail++; $display("FAIL resume_data got %h/%h want %h/%h", p1, p2, expv(q0), expv(q1)); end
  endtask

  task automatic test_reset_mid;
    int n;
    code0 = 12'hABC; code1 = 12'h123;
    until_valid(400, n);
    q0.push_back(code0); q1.push_back(code1);
    n_chk++;
    if (p1 !== expv(q0) || p2 !== expv(q1)) begin n_fail++; $display("FAIL mid_prior got %h/%h want %h/%h", p1, p2, expv(q0), expv(q1)); end
    until_cs(1'b0, 200, n);
    until_cs(1'b1, 200, n);
    until_cs(1'b0, 200, n);
    repeat (20) @(negedge clk);
    #2 reset = 0;
    #1;
    n_chk += 6;
    if (cs_n !== 1) begin n_fail++; $display("FAIL mid_cs_n got %b want 1", cs_n); end
    if (sclk !== 0) begin n_fail++; $display("FAIL mid_sclk got %b want 0", sclk); end
    if (mosi !== 0) begin n_fail++; $display("FAIL mid_mosi got %b want 0", mosi); end
    if (p1 !== 0) begin n_fail++; $display("FAIL mid_p1 got %h want 000", p1); end
    if (p2 !== 0) begin n_fail++; $display("FAIL mid_p2 got %h want 000", p2); end
    if (valid !== 0) begin n_fail++; $display("FAIL mid_valid got %b want 0", valid); end
    q0.delete(); q1.delete();
    @(negedge clk);
    reset = 1;
    until_valid(400, n);
    q0.push_back(code0); q1.push_back(code1);
    n_chk += 3;
    if (n != 143) begin n_fail++; $display("FAIL mid_latency got %0d want 143", n); end
    if (p1 !== expv(q0)) begin n_fail++; $display("FAIL mid_p1_new got %h want %h", p1, expv(q0)); end
    if (p2 !== expv(q1)) begin n_fail++; $display("FAIL mid_p2_new got %h want %h", p2, expv(q1)); end
  endtask

`ifdef ADC_AVG_EN
  task automatic test_avg;
    int n;
    logic [11:0] e1 [5] = '{12'h200, 12'h400, 12'h600, 12'h800, 12'h800};
    logic [11:0] e2 [5] = '{12'h100, 12'h200, 12'h300, 12'h400, 12'h400};
    @(negedge clk) reset = 0;
    code0 = 12'h800; code1 = 12'h400;
    @(negedge clk) reset = 1;
    for (int i = 0; i < 5; i++) begin
      until_valid(400, n);
      n_chk += 2;
      if (p1 !== e1[i]) begin n_fail++; $display("FAIL avg_p1[%0d] got %h want %h", i, p1, e1[i]); end
      if (p2 !== e2[i]) begin n_fail++; $display("FAIL avg_p2[%0d] got %h want %h", i, p2, e2[i]); end
    end
  endtask
`endif

  initial begin
    code0 = 12'hABC; code1 = 12'h123;
    test_reset;
    test_basic_pair;
    test_framing;
    test_random;
    test_enable_drop;
    test_reset_mid;
`ifdef ADC_AVG_EN
    test_avg;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule
